// File: rtl/mem_write_checker_pkg.sv
// Shared types and verdict priority for the store-stream self-check monitor.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_MISMATCH   = 3'd1,
        FC_TIMEOUT    = 3'd2,
        FC_EBREAK     = 3'd3,
        FC_INCOMPLETE = 3'd4
    } fail_code_e;

    // Bit positions of same-cycle verdict causes, lowest rank wins.
    localparam int RANK_MISMATCH   = 0;
    localparam int RANK_PASS       = 1;
    localparam int RANK_EBREAK     = 2;
    localparam int RANK_TIMEOUT    = 3;
    localparam int RANK_INCOMPLETE = 4;
    localparam int NUM_RANKS       = 5;

    typedef struct packed {
        logic       hit;
        fail_code_e code;
    } verdict_t;

    function automatic verdict_t resolve_verdict(input logic [NUM_RANKS-1:0] cond);
        verdict_t v;
        v.hit  = 1'b1;
        v.code = FC_NONE;
        if (cond[RANK_MISMATCH])        v.code = FC_MISMATCH;
        else if (cond[RANK_PASS])       v.code = FC_NONE;
        else if (cond[RANK_EBREAK])     v.code = FC_EBREAK;
        else if (cond[RANK_TIMEOUT])    v.code = FC_TIMEOUT;
        else if (cond[RANK_INCOMPLETE]) v.code = FC_INCOMPLETE;
        else                            v.hit  = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Core-side observation bus: data-memory write port plus program-end flags.
interface mem_write_checker_if #(
    parameter int XLEN = 32
) ();
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            ecall;
    logic            ebreak;

    modport master (output mem_we, mem_addr, mem_wdata, ecall, ebreak);
    modport slave  (input  mem_we, mem_addr, mem_wdata, ecall, ebreak);
endinterface

// File: rtl/mwc_expect_table.sv
// Expected (address, data) table with matched bits and combinational store lookup.
module mwc_expect_table
    import mem_write_checker_pkg::*;
#(
    parameter  int NUM_CHECKS = 4,
    parameter  int XLEN       = 32,
    parameter  int ORDERED    = 1,
    localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_N_W    = $clog2(NUM_CHECKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [XLEN-1:0]    wr_addr,
    input  logic [XLEN-1:0]    wr_data,
    input  logic               clr_matched,
    input  logic               set_matched,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic [CNT_N_W-1:0] num_act,
    input  logic [CNT_N_W-1:0] ptr,
    input  logic [XLEN-1:0]    st_addr,
    input  logic [XLEN-1:0]    st_data,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               data_ok
);

    logic [XLEN-1:0]       addr_q [NUM_CHECKS];
    logic [XLEN-1:0]       addr_d [NUM_CHECKS];
    logic [XLEN-1:0]       data_q [NUM_CHECKS];
    logic [XLEN-1:0]       data_d [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] matched_q;
    logic [NUM_CHECKS-1:0] matched_d;

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        matched_d = matched_q;
        if (clr_matched) begin
            matched_d = '0;
        end else if (set_matched) begin
            matched_d[set_idx] = 1'b1;
        end
        // Out-of-range indices match no entry and are dropped.
        if (wr_en) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (IDX_W'(i) == wr_idx) begin
                    addr_d[i] = wr_addr;
                    data_d[i] = wr_data;
                end
            end
        end
    end

    // NOTE: the table is a small flop array, not a RAM, so it is reset; a
    // restart after rst then compares against known zeros, never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '{default: '0};
            data_q    <= '{default: '0};
            matched_q <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            matched_q <= matched_d;
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        data_ok = 1'b0;
        if (ORDERED != 0) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (CNT_N_W'(i) == ptr && ptr < num_act && addr_q[i] == st_addr) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                    data_ok = (data_q[i] == st_data);
                end
            end
        end else begin
            // NOTE: blocking assignments in a descending loop: the last write
            // wins, so the lowest-index unmatched entry is the one reported.
            for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
                if (CNT_N_W'(i) < num_act && !matched_q[i] && addr_q[i] == st_addr) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                    data_ok = (data_q[i] == st_data);
                end
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Store-stream self-check monitor: FSM, counters and mismatch capture around the table.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int NUM_CHECKS     = 4,
    parameter  int TIMEOUT_CYCLES = 1000,
    parameter  int CNT_W          = 32,
    parameter  int ORDERED        = 1,
    localparam int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_N_W        = $clog2(NUM_CHECKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    mem_write_checker_if.slave bus,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [XLEN-1:0]    cfg_addr,
    input  logic [XLEN-1:0]    cfg_data,
    input  logic [CNT_N_W-1:0] cfg_num,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         fail_code,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_N_W-1:0] matched_count,
    output logic [XLEN-1:0]    bad_addr,
    output logic [XLEN-1:0]    bad_data
);

    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_N_W-1:0] NUM_MAX      = CNT_N_W'(NUM_CHECKS);

    state_e             state_q, state_d;
    fail_code_e         fail_code_q, fail_code_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_N_W-1:0] matched_count_q, matched_count_d;
    logic [CNT_N_W-1:0] num_act_q, num_act_d;
    logic [XLEN-1:0]    bad_addr_q, bad_addr_d;
    logic [XLEN-1:0]    bad_data_q, bad_data_d;

    logic               tbl_wr, tbl_clr, tbl_set;
    logic               tbl_hit, tbl_data_ok;
    logic [IDX_W-1:0]   tbl_hit_idx;
    logic               store_hit, match_ok;
    logic [CNT_N_W-1:0] count_after;
    logic [NUM_RANKS-1:0] cond;
    verdict_t           verdict;

    mwc_expect_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .XLEN       (XLEN),
        .ORDERED    (ORDERED)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (tbl_wr),
        .wr_idx      (cfg_idx),
        .wr_addr     (cfg_addr),
        .wr_data     (cfg_data),
        .clr_matched (tbl_clr),
        .set_matched (tbl_set),
        .set_idx     (tbl_hit_idx),
        .num_act     (num_act_q),
        .ptr         (matched_count_q),
        .st_addr     (bus.mem_addr),
        .st_data     (bus.mem_wdata),
        .hit         (tbl_hit),
        .hit_idx     (tbl_hit_idx),
        .data_ok     (tbl_data_ok)
    );

    always_comb begin
        state_d         = state_q;
        fail_code_d     = fail_code_q;
        cycle_count_d   = cycle_count_q;
        matched_count_d = matched_count_q;
        num_act_d       = num_act_q;
        bad_addr_d      = bad_addr_q;
        bad_data_d      = bad_data_q;
        tbl_wr          = cfg_we && (state_q == ST_IDLE);
        tbl_clr         = 1'b0;
        tbl_set         = 1'b0;
        cond            = '0;
        verdict         = '0;
        store_hit       = bus.mem_we && tbl_hit;
        match_ok        = store_hit && tbl_data_ok;
        count_after     = matched_count_q + CNT_N_W'(match_ok);

        if (start) begin
            state_d         = ST_RUN;
            num_act_d       = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
            fail_code_d     = FC_NONE;
            cycle_count_d   = '0;
            matched_count_d = '0;
            bad_addr_d      = '0;
            bad_data_d      = '0;
            tbl_clr         = 1'b1;
        end else if (state_q == ST_RUN) begin
            cond[RANK_MISMATCH]   = store_hit && !tbl_data_ok;
            cond[RANK_PASS]       = (count_after >= num_act_q);
            cond[RANK_EBREAK]     = bus.ebreak;
            cond[RANK_TIMEOUT]    = (cycle_count_q == TIMEOUT_LAST);
            cond[RANK_INCOMPLETE] = bus.ecall;
            verdict               = resolve_verdict(cond);
            tbl_set               = match_ok;
            matched_count_d       = count_after;
            if (verdict.hit) begin
                state_d     = (verdict.code == FC_NONE) ? ST_PASS : ST_FAIL;
                fail_code_d = verdict.code;
                if (verdict.code == FC_MISMATCH) begin
                    bad_addr_d = bus.mem_addr;
                    bad_data_d = bus.mem_wdata;
                end
            end else if (cycle_count_q != '1) begin
                // The verdict edge is not counted, so a timeout reads TIMEOUT_CYCLES-1.
                cycle_count_d = cycle_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fail_code_q     <= FC_NONE;
            cycle_count_q   <= '0;
            matched_count_q <= '0;
            num_act_q       <= '0;
            bad_addr_q      <= '0;
            bad_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            fail_code_q     <= fail_code_d;
            cycle_count_q   <= cycle_count_d;
            matched_count_q <= matched_count_d;
            num_act_q       <= num_act_d;
            bad_addr_q      <= bad_addr_d;
            bad_data_q      <= bad_data_d;
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass          = (state_q == ST_PASS);
    assign fail_code     = fail_code_q;
    assign cycle_count   = cycle_count_q;
    assign matched_count = matched_count_q;
    assign bad_addr      = bad_addr_q;
    assign bad_data      = bad_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: one ordered and one unordered checker fed identical stimulus.
module tb_mem_write_checker;

    localparam int XLEN           = 32;
    localparam int NUM_CHECKS     = 4;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int CNT_W          = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_idx = '0;
    logic [XLEN-1:0]   cfg_addr = '0;
    logic [XLEN-1:0]   cfg_data = '0;
    logic [2:0]        cfg_num = '0;
    logic              start = 1'b0;
    logic              mem_we = 1'b0;
    logic [XLEN-1:0]   mem_addr = '0;
    logic [XLEN-1:0]   mem_wdata = '0;
    logic              ecall = 1'b0;
    logic              ebreak = 1'b0;

    logic              busy_o, done_o, pass_o, busy_u, done_u, pass_u;
    logic [2:0]        fail_code_o, fail_code_u;
    logic [CNT_W-1:0]  cycle_o, cycle_u;
    logic [2:0]        matched_o, matched_u;
    logic [XLEN-1:0]   bad_addr_o, bad_data_o, bad_addr_u, bad_data_u;

    int checks = 0;
    int errors = 0;

    mem_write_checker_if #(.XLEN(XLEN)) bus_o ();
    mem_write_checker_if #(.XLEN(XLEN)) bus_u ();

    assign bus_o.mem_we    = mem_we;
    assign bus_o.mem_addr  = mem_addr;
    assign bus_o.mem_wdata = mem_wdata;
    assign bus_o.ecall     = ecall;
    assign bus_o.ebreak    = ebreak;
    assign bus_u.mem_we    = mem_we;
    assign bus_u.mem_addr  = mem_addr;
    assign bus_u.mem_wdata = mem_wdata;
    assign bus_u.ecall     = ecall;
    assign bus_u.ebreak    = ebreak;

    mem_write_checker #(
        .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W(CNT_W), .ORDERED(1)
    ) dut_o (
        .clk(clk), .rst(rst), .bus(bus_o),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_num(cfg_num), .start(start),
        .busy(busy_o), .done(done_o), .pass(pass_o), .fail_code(fail_code_o),
        .cycle_count(cycle_o), .matched_count(matched_o),
        .bad_addr(bad_addr_o), .bad_data(bad_data_o)
    );

    mem_write_checker #(
        .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W(CNT_W), .ORDERED(0)
    ) dut_u (
        .clk(clk), .rst(rst), .bus(bus_u),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_num(cfg_num), .start(start),
        .busy(busy_u), .done(done_u), .pass(pass_u), .fail_code(fail_code_u),
        .cycle_count(cycle_u), .matched_count(matched_u),
        .bad_addr(bad_addr_u), .bad_data(bad_data_u)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        mem_we    = 1'b0;
    endtask

    task automatic go(input int num);
        cfg_num = 3'(num);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_fail_code", fail_code_o, 0);
        check("rst_cycle", cycle_o, 0);
        check("rst_matched", matched_o, 0);
        check("rst_bad_addr", bad_addr_o, 0);
        rst = 1'b0;
        tick();

        // Ordered pass with an ignored store first
        load(0, 32'h80, 32'h1234_5678);
        load(1, 32'h84, 32'hABCD_E02E);
        go(2);
        check("ord_busy_after_start", busy_o, 1);
        check("ord_cycle_after_start", cycle_o, 0);
        store(32'h40, 32'h0000_DEAD);
        check("ord_ignored_matched", matched_o, 0);
        check("ord_ignored_cycle", cycle_o, 1);
        store(32'h80, 32'h1234_5678);
        check("ord_first_matched", matched_o, 1);
        check("ord_first_pass", pass_o, 0);
        store(32'h84, 32'hABCD_E02E);
        check("ord_pass", pass_o, 1);
        check("ord_done", done_o, 1);
        check("ord_busy_end", busy_o, 0);
        check("ord_fail_code", fail_code_o, 0);
        check("ord_matched", matched_o, 2);
        check("ord_cycle_end", cycle_o, 2);
        check("unord_inorder_pass", pass_u, 1);
        tick();
        check("ord_pass_hold", pass_o, 1);
        check("ord_cycle_hold", cycle_o, 2);

        // Mismatch: unordered flags it, ordered ignores the out-of-order address
        go(2);
        check("mm_restart_matched", matched_o, 0);
        check("mm_restart_pass", pass_o, 0);
        store(32'h84, 32'hABCD_E02F);
        check("mm_u_fail_code", fail_code_u, 1);
        check("mm_u_bad_addr", bad_addr_u, 32'h84);
        check("mm_u_bad_data", bad_data_u, 32'hABCD_E02F);
        check("mm_u_done", done_u, 1);
        check("mm_o_still_busy", busy_o, 1);
        check("mm_o_fail_code", fail_code_o, 0);
        store(32'h80, 32'h0000_0000);
        check("mm_o_fail_code2", fail_code_o, 1);
        check("mm_o_bad_addr", bad_addr_o, 32'h80);
        check("mm_o_bad_data", bad_data_o, 32'h0);
        check("mm_u_hold", fail_code_u, 1);

        // Timeout: restart from FAIL clears everything, fail after 10 RUN edges
        go(1);
        check("to_restart_cycle", cycle_o, 0);
        check("to_restart_fail_code", fail_code_o, 0);
        check("to_restart_bad_addr", bad_addr_o, 0);
        check("to_restart_bad_addr_u", bad_addr_u, 0);
        check("to_restart_busy", busy_o, 1);
        repeat (9) tick();
        check("to_edge9_busy", busy_o, 1);
        check("to_edge9_cycle", cycle_o, 9);
        tick();
        check("to_fail_code", fail_code_o, 2);
        check("to_cycle", cycle_o, 9);
        check("to_done", done_o, 1);
        check("to_fail_code_u", fail_code_u, 2);

        // ecall with one of two matched
        go(2);
        store(32'h80, 32'h1234_5678);
        ecall = 1'b1;
        tick();
        ecall = 1'b0;
        check("ecall_incomplete", fail_code_o, 4);
        check("ecall_incomplete_pass", pass_o, 0);
        check("ecall_incomplete_matched", matched_o, 1);

        // ecall in the same cycle as the final match
        go(2);
        store(32'h80, 32'h1234_5678);
        ecall = 1'b1;
        store(32'h84, 32'hABCD_E02E);
        ecall = 1'b0;
        check("ecall_final_pass", pass_o, 1);
        check("ecall_final_code", fail_code_o, 0);
        check("ecall_final_pass_u", pass_u, 1);

        // ebreak
        go(2);
        ebreak = 1'b1;
        tick();
        ebreak = 1'b0;
        check("ebreak_code", fail_code_o, 3);
        check("ebreak_code_u", fail_code_u, 3);

        // Unordered: reverse order, plus a store to an already-matched address
        go(2);
        store(32'h84, 32'hABCD_E02E);
        check("unord_first_matched_u", matched_u, 1);
        check("unord_first_matched_o", matched_o, 0);
        store(32'h84, 32'h0BAD_0BAD);
        check("unord_rematch_ignored", fail_code_u, 0);
        check("unord_rematch_busy", busy_u, 1);
        store(32'h80, 32'h1234_5678);
        check("unord_pass", pass_u, 1);
        check("unord_matched", matched_u, 2);
        check("unord_o_partial", matched_o, 1);
        check("unord_o_busy", busy_o, 1);

        // Final match on the timeout edge wins
        go(1);
        repeat (9) tick();
        store(32'h80, 32'h1234_5678);
        check("to_match_pass", pass_o, 1);
        check("to_match_code", fail_code_o, 0);
        check("to_match_cycle", cycle_o, 9);

        // cfg_we while running is ignored
        go(1);
        load(0, 32'h90, 32'h1);
        store(32'h80, 32'h1234_5678);
        check("cfg_in_run_ignored", pass_o, 1);

        // cfg_num = 0 passes on the first RUN edge
        go(0);
        check("num0_busy", busy_o, 1);
        tick();
        check("num0_pass", pass_o, 1);
        check("num0_matched", matched_o, 0);

        // Asynchronous reset mid-RUN clears state and table
        go(2);
        store(32'h80, 32'h1234_5678);
        check("rst_mid_pre_matched", matched_o, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_matched", matched_o, 0);
        check("rst_mid_cycle", cycle_o, 0);
        tick();
        rst = 1'b0;
        go(1);
        store(32'h80, 32'h1234_5678);
        check("rst_table_cleared_busy", busy_o, 1);
        check("rst_table_cleared_matched", matched_o, 0);
        store(32'h0, 32'h0);
        check("rst_table_zero_pass", pass_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
